// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data memory.
// Port 0 is the load/store unit, port 1 the DMA/debug loader; read data returns one cycle after grant.
module data_mem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MEM_SIZE = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             mem_write,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  logic             r_last_winner;
  logic             r0_pend;
  logic             r1_pend;
  logic [WIDTH-1:0] r0_rdata;
  logic [WIDTH-1:0] r1_rdata;

  logic             w_any;
  logic             w_win1;
  logic             w_sel_we;
  logic [WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic             w_rd0;
  logic             w_rd1;
  logic             w_unused;

  // Port 1 wins when alone, or when both request and port 0 had the last grant
  assign w_any  = rst_n & (m0_req | m1_req);
  assign w_win1 = m1_req & (~m0_req | ~r_last_winner);

  assign m0_gnt = w_any & ~w_win1;
  assign m1_gnt = w_any &  w_win1;

  assign w_sel_we    = w_win1 ? m1_we    : m0_we;
  assign w_sel_addr  = w_win1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win1 ? m1_wdata : m0_wdata;

  // Upper address bits lie outside the memory and are dropped
  assign w_unused = ^w_sel_addr[WIDTH-1:MEM_SIZE];

  assign mem_write = w_any &  w_sel_we;
  assign mem_read  = w_any & ~w_sel_we;
  assign mem_addr  = w_any ? WIDTH'(w_sel_addr[MEM_SIZE-1:0]) : '0;
  assign mem_wdata = w_any ? w_sel_wdata : '0;

  assign w_rd0 = m0_gnt & ~m0_we;
  assign w_rd1 = m1_gnt & ~m1_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_winner <= 1'b1;
      r0_pend       <= 1'b0;
      r1_pend       <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
    end else begin
      r0_pend <= w_rd0;
      r1_pend <= w_rd1;
      if (w_any) r_last_winner <= w_win1;
      if (w_rd0) r0_rdata <= mem_rdata;
      if (w_rd1) r1_rdata <= mem_rdata;
    end
  end

  assign m0_rvalid = r0_pend;
  assign m0_rdata  = r0_rdata;
  assign m1_rvalid = r1_pend;
  assign m1_rdata  = r1_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural Data_Mem stand-in, reference memory and
// per-port read-data scoreboard queues.
module tb_data_mem_arbiter;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MEM_SIZE = 7;
  localparam int unsigned DEPTH    = 1 << MEM_SIZE;

  logic             clk;
  logic             rst_n;
  logic             m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [WIDTH-1:0] m0_addr, m0_wdata, m0_rdata;
  logic             m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [WIDTH-1:0] m1_addr, m1_wdata, m1_rdata;
  logic             mem_write, mem_read;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

  logic [WIDTH-1:0] dmem    [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] exp_rd0, exp_rd1;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.WIDTH(WIDTH), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_Mem stand-in: combinational read, write on posedge
  assign mem_rdata = dmem[mem_addr[MEM_SIZE-1:0]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[MEM_SIZE-1:0]] <= mem_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete();
    exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    clear_model();
    @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle: drive at negedge, check grant/memory port, then rvalid/rdata after posedge
  task automatic step(input logic r0, input logic w0, input logic [WIDTH-1:0] a0,
                      input logic [WIDTH-1:0] d0, input logic r1, input logic w1,
                      input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] d1,
                      input int exp_w, input string tag);
    logic             ew, v0, v1;
    logic [WIDTH-1:0] ea, ed;
    logic [MEM_SIZE-1:0] idx;
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    ew = 0; ea = '0; ed = '0;
    if (exp_w == 0) begin ew = w0; ea = a0 & 32'h7F; ed = d0; end
    if (exp_w == 1) begin ew = w1; ea = a1 & 32'h7F; ed = d1; end
    checks++;
    if (m0_gnt !== (exp_w == 0)) begin errors++; $display("FAIL %s m0_gnt got %b exp %b", tag, m0_gnt, exp_w == 0); end
    checks++;
    if (m1_gnt !== (exp_w == 1)) begin errors++; $display("FAIL %s m1_gnt got %b exp %b", tag, m1_gnt, exp_w == 1); end
    checks++;
    if (mem_write !== (exp_w >= 0 && ew)) begin errors++; $display("FAIL %s mem_write got %b", tag, mem_write); end
    checks++;
    if (mem_read !== (exp_w >= 0 && !ew)) begin errors++; $display("FAIL %s mem_read got %b", tag, mem_read); end
    checks++;
    if (mem_addr !== ea) begin errors++; $display("FAIL %s mem_addr got %h exp %h", tag, mem_addr, ea); end
    checks++;
    if (mem_wdata !== ed) begin errors++; $display("FAIL %s mem_wdata got %h exp %h", tag, mem_wdata, ed); end
    v0 = 0; v1 = 0;
    idx = ea[MEM_SIZE-1:0];
    if (exp_w >= 0) begin
      if (ew) ref_mem[idx] = ed;
      else if (exp_w == 0) begin q0.push_back(ref_mem[idx]); v0 = 1; end
      else begin q1.push_back(ref_mem[idx]); v1 = 1; end
    end
    @(posedge clk);
    #1;
    if (v0 && q0.size() > 0) exp_rd0 = q0.pop_front();
    if (v1 && q1.size() > 0) exp_rd1 = q1.pop_front();
    checks++;
    if (m0_rvalid !== v0) begin errors++; $display("FAIL %s m0_rvalid got %b exp %b", tag, m0_rvalid, v0); end
    checks++;
    if (m1_rvalid !== v1) begin errors++; $display("FAIL %s m1_rvalid got %b exp %b", tag, m1_rvalid, v1); end
    checks++;
    if (m0_rdata !== exp_rd0) begin errors++; $display("FAIL %s m0_rdata got %h exp %h", tag, m0_rdata, exp_rd0); end
    checks++;
    if (m1_rdata !== exp_rd1) begin errors++; $display("FAIL %s m1_rdata got %h exp %h", tag, m1_rdata, exp_rd1); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 32'h3; m0_wdata = 32'hDEAD_BEEF;
    m1_req = 1; m1_we = 0; m1_addr = 32'h4;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset gnt got %b exp 00", {m0_gnt, m1_gnt}); end
    checks++;
    if ({mem_write, mem_read} !== 2'b00) begin errors++; $display("FAIL reset mem_rw got %b exp 00", {mem_write, mem_read}); end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset mem_bus got %h exp 0", {mem_addr, mem_wdata}); end
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'h0) begin
      errors++; $display("FAIL reset rsp got %b %b %h %h exp 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    step(1, 1, 32'd5, 32'hA5A5_0001, 0, 0, '0, '0, 0, "wr_a5");
    step(1, 0, 32'd5, '0,            0, 0, '0, '0, 0, "rd_a5");
    checks++;
    if (m0_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL raw_a5 m0_rdata got %h exp a5a50001", m0_rdata); end
    step(0, 0, '0, '0, 0, 0, '0, '0, -1, "idle_a5");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 0, 32'(10 + (i + 1) / 2), '0, 1, 0, 32'(30 + i / 2), '0, i % 2, $sformatf("rr%0d", i));
    step(0, 0, '0, '0, 0, 0, '0, '0, -1, "rr_idle");
  endtask

  task automatic test_addr_mask();
    step(0, 0, '0, '0, 1, 1, 32'h0000_0085, 32'hCAFE_0085, 1, "m1_wr85");
    step(1, 0, 32'd5, '0, 0, 0, '0, '0, 0, "m0_rd5");
    checks++;
    if (m0_rdata !== 32'hCAFE_0085) begin errors++; $display("FAIL mask m0_rdata got %h exp cafe0085", m0_rdata); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 0, '0, '0, -1, $sformatf("idle%0d", i));
    step(1, 0, 32'd20, '0, 1, 0, 32'd21, '0, 1, "idle_cont");
    step(1, 0, 32'd20, '0, 0, 0, '0,     '0, 0, "idle_m0");
    step(0, 0, '0, '0, 0, 0, '0, '0, -1, "idle_end");
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'd7;
    #1;
    checks++;
    if (m0_gnt !== 1'b1) begin errors++; $display("FAIL midrst pre gnt got %b exp 1", m0_gnt); end
    #1 rst_n = 0;
    clear_model();
    #1;
    checks++;
    if ({m0_gnt, mem_read} !== 2'b00) begin errors++; $display("FAIL midrst gnt_rd got %b exp 00", {m0_gnt, mem_read}); end
    @(posedge clk);
    #1;
    checks++;
    if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL midrst m0_rvalid got %b exp 0", m0_rvalid); end
    checks++;
    if (m0_rdata !== '0) begin errors++; $display("FAIL midrst m0_rdata got %h exp 0", m0_rdata); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    step(1, 0, 32'd7, '0, 1, 0, 32'd8, '0, 0, "post_rst_cont");
    step(0, 0, '0,    '0, 1, 0, 32'd8, '0, 1, "post_rst_m1");
  endtask

  task automatic test_raw_contended();
    step(1, 1, 32'd9, 32'h1234, 1, 0, 32'd9, '0, 0, "raw_both");
    step(0, 0, '0,    '0,       1, 0, 32'd9, '0, 1, "raw_m1");
    checks++;
    if (m1_rdata !== 32'h1234) begin errors++; $display("FAIL raw m1_rdata got %h exp 1234", m1_rdata); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 32'd40, 32'h5555_0040, 0, 0, '0, '0, 0, "b2b_wr1");
    step(1, 0, 32'd40, '0,            0, 0, '0, '0, 0, "b2b_rd1");
    step(1, 1, 32'd40, 32'h6666_0040, 0, 0, '0, '0, 0, "b2b_wr2");
    step(1, 0, 32'd40, '0,            0, 0, '0, '0, 0, "b2b_rd2");
    step(1, 0, 32'd40, '0,            0, 0, '0, '0, 0, "b2b_rd3");
    step(0, 0, '0, '0, 0, 0, '0, '0, -1, "b2b_idle");
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      dmem[i]    = 32'h1000_0000 + 32'(i * 3);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 3);
    end
    idle_inputs();
    clear_model();
    rst_n = 0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_addr_mask();
    test_idle();
    test_reset_mid_read();
    test_raw_contended();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
